// File: rtl/rapcore_io_ctrl.sv
// rapcore_io_ctrl: Wishbone-programmable pad controller between the Caravel
// user I/O and rapcore. A per-pad SEL bit hands each pad either to rapcore
// (core_out_i/core_oeb_i) or to software GPIO (OUT/OEB registers). Pad inputs
// pass through a 2-flop synchroniser to the core and to the IN register.
//
// Optional feature macro: IO_EDGE_CAPTURE_EN
//   defined   : third sync stage, rising-edge capture into EDGE (W1C),
//               IRQEN mask and registered level interrupt irq_o
//   undefined : EDGE/IRQEN read 0 and ignore writes, irq_o tied 0
//
// Ports
//   wb_clk_i, wb_rst_ni       clock, async active-low reset
//   wbs_stb_i/cyc_i/we_i      Wishbone strobe, cycle, write enable
//   wbs_sel_i[3:0]            byte lane enables
//   wbs_adr_i[31:0]           byte address (decoded on [31:8])
//   wbs_dat_i[31:0]           write data
//   wbs_ack_o                 registered one-cycle acknowledge
//   wbs_dat_o[31:0]           registered read data, 0 when ack is low
//   core_out_i/core_oeb_i     rapcore pad drive
//   core_in_o                 synchronised pad inputs to rapcore
//   io_in/io_out/io_oeb       Caravel user pads (io_oeb 1 = input)
//   irq_o                     level interrupt
//
// Register map (word offsets, LO = pads 0..31, HI = pads 32..NPADS-1)
//   0x00/04 SEL   0x08/0C OEB   0x10/14 OUT   0x18/1C IN (RO)
//   0x20/24 EDGE (W1C)          0x28/2C IRQEN

module rapcore_io_ctrl #(
  parameter int unsigned NPADS     = 38,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [63:0] RESET_SEL = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             wbs_stb_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  input  logic [NPADS-1:0] core_out_i,
  input  logic [NPADS-1:0] core_oeb_i,
  output logic [NPADS-1:0] core_in_o,
  input  logic [NPADS-1:0] io_in,
  output logic [NPADS-1:0] io_out,
  output logic [NPADS-1:0] io_oeb,
  output logic             irq_o
);

  localparam int unsigned DW    = 32;
  localparam int unsigned RW    = 64;
  localparam int unsigned RIDXW = 5;

  localparam logic [RIDXW-1:0] R_SEL   = 5'd0;
  localparam logic [RIDXW-1:0] R_OEB   = 5'd1;
  localparam logic [RIDXW-1:0] R_OUT   = 5'd2;
  localparam logic [RIDXW-1:0] R_IN    = 5'd3;
  localparam logic [RIDXW-1:0] R_EDGE  = 5'd4;
  localparam logic [RIDXW-1:0] R_IRQEN = 5'd5;

  // Replace the enabled byte lanes of one 32-bit half of a 64-bit register view.
  function automatic logic [RW-1:0] lane_merge(input logic [RW-1:0] old_v,
                                               input logic          hi,
                                               input logic [DW-1:0] d,
                                               input logic [3:0]    be);
    logic [DW-1:0] half;
    half = hi ? old_v[63:32] : old_v[31:0];
    for (int b = 0; b < 4; b++) begin
      if (be[b]) half[8*b +: 8] = d[8*b +: 8];
    end
    return hi ? {half, old_v[31:0]} : {old_v[63:32], half};
  endfunction

  logic             ack_q;
  logic [DW-1:0]    dat_q;
  logic [NPADS-1:0] sel_q;
  logic [NPADS-1:0] oeb_q;
  logic [NPADS-1:0] out_q;
  logic [NPADS-1:0] sync1_q;
  logic [NPADS-1:0] sync2_q;

  logic             hit_c;
  logic             xfer_c;
  logic             wr_c;
  logic             hi_c;
  logic [RIDXW-1:0] ridx_c;
  logic [RW-1:0]    rd64_c;
  logic [DW-1:0]    rd_data_c;

  // Byte-address bits below the word are not decoded.
  logic unused_adr_lsb;
  assign unused_adr_lsb = &{1'b0, wbs_adr_i[1:0]};

  // Bus decode: one transfer per ack, so a held request is not re-served on the ack cycle.
  assign hit_c  = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign xfer_c = wbs_cyc_i & wbs_stb_i & hit_c & ~ack_q;
  assign wr_c   = xfer_c & wbs_we_i;
  assign hi_c   = wbs_adr_i[2];
  assign ridx_c = wbs_adr_i[7:3];

`ifdef IO_EDGE_CAPTURE_EN
  logic [NPADS-1:0] sync3_q;
  logic [NPADS-1:0] edge_q;
  logic [NPADS-1:0] irqen_q;
  logic             irq_q;
  logic [NPADS-1:0] edge_clr_c;

  // W1C mask honouring byte lanes; bits above NPADS drop out in the cast.
  always_comb begin
    edge_clr_c = '0;
    if (wr_c && (ridx_c == R_EDGE)) begin
      edge_clr_c = NPADS'(lane_merge('0, hi_c, wbs_dat_i, wbs_sel_i));
    end
  end
`endif

  // Read data mux over zero-extended register views.
  always_comb begin
    rd64_c = '0;
    case (ridx_c)
      R_SEL:   rd64_c = RW'(sel_q);
      R_OEB:   rd64_c = RW'(oeb_q);
      R_OUT:   rd64_c = RW'(out_q);
      R_IN:    rd64_c = RW'(sync2_q);
`ifdef IO_EDGE_CAPTURE_EN
      R_EDGE:  rd64_c = RW'(edge_q);
      R_IRQEN: rd64_c = RW'(irqen_q);
`endif
      default: rd64_c = '0;
    endcase
    rd_data_c = hi_c ? rd64_c[63:32] : rd64_c[31:0];
  end

  // Wishbone slave registers; writes land on the edge that raises ack.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_q   <= 1'b0;
      dat_q   <= '0;
      sel_q   <= NPADS'(RESET_SEL);
      oeb_q   <= '1;
      out_q   <= '0;
`ifdef IO_EDGE_CAPTURE_EN
      irqen_q <= '0;
`endif
    end else begin
      ack_q <= xfer_c;
      dat_q <= (xfer_c && !wbs_we_i) ? rd_data_c : '0;
      if (wr_c) begin
        case (ridx_c)
          R_SEL:   sel_q   <= NPADS'(lane_merge(RW'(sel_q), hi_c, wbs_dat_i, wbs_sel_i));
          R_OEB:   oeb_q   <= NPADS'(lane_merge(RW'(oeb_q), hi_c, wbs_dat_i, wbs_sel_i));
          R_OUT:   out_q   <= NPADS'(lane_merge(RW'(out_q), hi_c, wbs_dat_i, wbs_sel_i));
`ifdef IO_EDGE_CAPTURE_EN
          R_IRQEN: irqen_q <= NPADS'(lane_merge(RW'(irqen_q), hi_c, wbs_dat_i, wbs_sel_i));
`endif
          default: ;
        endcase
      end
    end
  end

  // Input synchroniser (and optional edge capture / interrupt).
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
`ifdef IO_EDGE_CAPTURE_EN
      sync3_q <= '0;
      edge_q  <= '0;
      irq_q   <= 1'b0;
`endif
    end else begin
      sync1_q <= io_in;
      sync2_q <= sync1_q;
`ifdef IO_EDGE_CAPTURE_EN
      sync3_q <= sync2_q;
      // New edges win over a simultaneous clear.
      edge_q  <= (edge_q & ~edge_clr_c) | (sync2_q & ~sync3_q);
      irq_q   <= |(edge_q & irqen_q);
`endif
    end
  end

  // Pad ownership mux: SEL=1 software, SEL=0 rapcore.
  assign io_out = (sel_q & out_q) | (~sel_q & core_out_i);
  assign io_oeb = (sel_q & oeb_q) | (~sel_q & core_oeb_i);

  assign core_in_o = sync2_q;
  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
`ifdef IO_EDGE_CAPTURE_EN
  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_rapcore_io_ctrl.sv
// Self-checking bench for rapcore_io_ctrl: Wishbone reads push the expected
// word into a queue, which is popped and compared when ack returns.
module tb_rapcore_io_ctrl;

  localparam int unsigned NPADS = 38;
  localparam logic [31:0] BASE  = 32'h3000_0000;

  localparam logic [31:0] A_SEL_LO   = BASE + 32'h00;
  localparam logic [31:0] A_SEL_HI   = BASE + 32'h04;
  localparam logic [31:0] A_OEB_LO   = BASE + 32'h08;
  localparam logic [31:0] A_OEB_HI   = BASE + 32'h0C;
  localparam logic [31:0] A_OUT_LO   = BASE + 32'h10;
  localparam logic [31:0] A_OUT_HI   = BASE + 32'h14;
  localparam logic [31:0] A_IN_HI    = BASE + 32'h1C;
  localparam logic [31:0] A_EDGE_LO  = BASE + 32'h20;
  localparam logic [31:0] A_IRQEN_LO = BASE + 32'h28;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             stb, cyc, we;
  logic [3:0]       be;
  logic [31:0]      adr, wdat;
  logic             ack;
  logic [31:0]      rdat;
  logic [NPADS-1:0] core_out, core_oeb, core_in;
  logic [NPADS-1:0] io_in, io_out, io_oeb;
  logic             irq;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  rapcore_io_ctrl dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .wbs_stb_i (stb),
    .wbs_cyc_i (cyc),
    .wbs_we_i  (we),
    .wbs_sel_i (be),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_ack_o (ack),
    .wbs_dat_o (rdat),
    .core_out_i(core_out),
    .core_oeb_i(core_oeb),
    .core_in_o (core_in),
    .io_in     (io_in),
    .io_out    (io_out),
    .io_oeb    (io_oeb),
    .irq_o     (irq)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One Wishbone transfer; reads are scored against the queue head on ack.
  task automatic wb_xfer(input string tag, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s,
                         input logic [31:0] exp_rd);
    logic        got_ack;
    logic [31:0] cap;
    logic [31:0] e;
    if (!w) exp_q.push_back(exp_rd);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; be = s;
    got_ack = 1'b0;
    cap = '0;
    for (int n = 0; n < 8 && !got_ack; n++) begin
      @(posedge clk); #1;
      if (ack) begin
        got_ack = 1'b1;
        cap = rdat;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    if (!got_ack) check({tag, "_ack_timeout"}, 64'(got_ack), 64'd1);
    if (!w) begin
      e = exp_q.pop_front();
      if (got_ack) check(tag, 64'(cap), 64'(e));
    end
    @(posedge clk); #1;
    check({tag, "_ack_width"}, 64'(ack), 64'd0);
  endtask

  task automatic wait_clks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    rst_n = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0; be = '0; adr = '0; wdat = '0;
    core_out = '0; core_oeb = '0; io_in = '0;
    wait_clks(3);
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_dat", 64'(rdat), 64'd0);
    check("rst_irq", 64'(irq), 64'd0);
    check("rst_io_oeb", 64'(io_oeb), 64'h3F_FFFF_FFFF);
    @(negedge clk); rst_n = 1'b1;
    wait_clks(2);

    // Reset values through the bus
    wb_xfer("sel_lo_rst", 1'b0, A_SEL_LO, '0, 4'hF, 32'hFFFF_FFFF);
    wb_xfer("sel_hi_rst", 1'b0, A_SEL_HI, '0, 4'hF, 32'h0000_003F);
    wb_xfer("oeb_lo_rst", 1'b0, A_OEB_LO, '0, 4'hF, 32'hFFFF_FFFF);
    wb_xfer("oeb_hi_rst", 1'b0, A_OEB_HI, '0, 4'hF, 32'h0000_003F);
    wb_xfer("out_lo_rst", 1'b0, A_OUT_LO, '0, 4'hF, 32'h0);

    // Hand pads 0..31 to rapcore
    core_out[15] = 1'b1; core_oeb[15] = 1'b0;
    wb_xfer("sel_lo_wr0", 1'b1, A_SEL_LO, 32'h0, 4'hF, '0);
    check("core_out15_hi", 64'(io_out[15]), 64'd1);
    check("core_oeb15_lo", 64'(io_oeb[15]), 64'd0);
    core_out[15] = 1'b0; core_oeb[15] = 1'b1; #1;
    check("core_out15_lo", 64'(io_out[15]), 64'd0);
    check("core_oeb15_hi", 64'(io_oeb[15]), 64'd1);
    wb_xfer("sel_lo_wr1", 1'b1, A_SEL_LO, 32'hFFFF_FFFF, 4'hF, '0);

    // Byte-lane writes
    wb_xfer("out_lo_b0", 1'b1, A_OUT_LO, 32'h0000_00A5, 4'b0001, '0);
    wb_xfer("out_lo_b1", 1'b1, A_OUT_LO, 32'h0000_FF00, 4'b0010, '0);
    wb_xfer("out_lo_rd", 1'b0, A_OUT_LO, '0, 4'hF, 32'h0000_FFA5);
    wb_xfer("oeb_lo_wr", 1'b1, A_OEB_LO, 32'h0, 4'hF, '0);
    check("io_out_7_0", 64'(io_out[7:0]), 64'hA5);
    check("io_oeb_7_0", 64'(io_oeb[7:0]), 64'h00);

    // Bits above NPADS are not stored
    wb_xfer("out_hi_wr", 1'b1, A_OUT_HI, 32'hFFFF_FFFF, 4'hF, '0);
    wb_xfer("out_hi_rd", 1'b0, A_OUT_HI, '0, 4'hF, 32'h0000_003F);

    // Synchroniser latency
    @(posedge clk); #1; io_in[33] = 1'b1;
    @(posedge clk); #1;
    check("sync_1clk", 64'(core_in[33]), 64'd0);
    @(posedge clk); #1;
    check("sync_2clk", 64'(core_in[33]), 64'd1);
    wb_xfer("in_hi_rd", 1'b0, A_IN_HI, '0, 4'hF, 32'h0000_0002);

    // Unmapped offsets inside the window
    wb_xfer("unmap_wr", 1'b1, BASE + 32'h30, 32'hDEAD_BEEF, 4'hF, '0);
    wb_xfer("unmap_rd30", 1'b0, BASE + 32'h30, '0, 4'hF, 32'h0);

    // Address miss: never acked
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h100;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    cyc = 1'b0; stb = 1'b0;
    check("miss_no_ack", 64'(acks), 64'd0);

`ifdef IO_EDGE_CAPTURE_EN
    wb_xfer("irqen_wr", 1'b1, A_IRQEN_LO, 32'h0000_0200, 4'hF, '0);
    wb_xfer("irqen_rd", 1'b0, A_IRQEN_LO, '0, 4'hF, 32'h0000_0200);
    @(posedge clk); #1; io_in[9] = 1'b1;
    wait_clks(5);
    check("irq_set", 64'(irq), 64'd1);
    wb_xfer("edge_rd1", 1'b0, A_EDGE_LO, '0, 4'hF, 32'h0000_0200);
    io_in[9] = 1'b0;
    wait_clks(4);
    // New rising edge timed to land on the W1C write edge
    io_in[9] = 1'b1;
    wait_clks(2);
    wb_xfer("edge_clr_race", 1'b1, A_EDGE_LO, 32'h0000_0200, 4'hF, '0);
    wb_xfer("edge_rd2", 1'b0, A_EDGE_LO, '0, 4'hF, 32'h0000_0200);
    check("irq_held", 64'(irq), 64'd1);
    wb_xfer("edge_clr", 1'b1, A_EDGE_LO, 32'h0000_0200, 4'hF, '0);
    check("irq_clr", 64'(irq), 64'd0);
    wb_xfer("edge_rd3", 1'b0, A_EDGE_LO, '0, 4'hF, 32'h0);
`else
    wb_xfer("irqen_wr", 1'b1, A_IRQEN_LO, 32'h0000_0200, 4'hF, '0);
    wb_xfer("irqen_rd", 1'b0, A_IRQEN_LO, '0, 4'hF, 32'h0);
    @(posedge clk); #1; io_in[9] = 1'b1;
    wait_clks(5);
    check("irq_off", 64'(irq), 64'd0);
    wb_xfer("edge_rd_off", 1'b0, A_EDGE_LO, '0, 4'hF, 32'h0);
`endif

    // Reset while ack is high: ack drops asynchronously
    core_oeb = '0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = A_OUT_LO; wdat = 32'h1234_5678; be = 4'hF;
    @(posedge clk); #1;
    check("ack_pre_rst", 64'(ack), 64'd1);
    rst_n = 1'b0; #1;
    check("ack_rst_async", 64'(ack), 64'd0);
    check("io_out_rst", 64'(io_out), 64'd0);
    check("io_oeb_rst", 64'(io_oeb), 64'h3F_FFFF_FFFF);
    @(negedge clk); rst_n = 1'b1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    wait_clks(1);

    // Reset before the write edge: the write is lost
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = A_OUT_LO; wdat = 32'h0000_0055; be = 4'hF;
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    check("ack_in_rst", 64'(ack), 64'd0);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    rst_n = 1'b1;
    wait_clks(1);
    wb_xfer("out_lo_lost", 1'b0, A_OUT_LO, '0, 4'hF, 32'h0);
    wb_xfer("sel_lo_after", 1'b0, A_SEL_LO, '0, 4'hF, 32'hFFFF_FFFF);
    wb_xfer("sel_hi_after", 1'b0, A_SEL_HI, '0, 4'hF, 32'h0000_003F);
    wb_xfer("unmap_rd3c", 1'b0, BASE + 32'h3C, '0, 4'hF, 32'h0);

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
